// File: rtl/key_debounce8.sv
// Eight-key synchroniser and debouncer feeding the 8-to-3 priority encoder.
// "release" is a reserved word, so the release strobe port is named key_release.
module key_debounce8 #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_n,
  input  logic       freeze,
  output logic [7:0] key_db_n,
  output logic [7:0] press,
  output logic [7:0] key_release,
  output logic       any_down
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [CNT_W-1:0] cnt [8];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 8'hFF;
      sync2       <= 8'hFF;
      key_db_n    <= 8'hFF;
      press       <= 8'h00;
      key_release <= 8'h00;
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      press       <= 8'h00;
      key_release <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (freeze || (sync2[i] == key_db_n[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end else begin
          // Level held for the full window: accept it and strobe the edge.
          key_db_n[i]    <= sync2[i];
          cnt[i]         <= '0;
          press[i]       <= ~sync2[i];
          key_release[i] <= sync2[i];
        end
      end
    end
  end

  assign any_down = ~&key_db_n;

endmodule

// File: tb/tb_key_debounce8.sv
// Bench for key_debounce8: directed scenarios plus random bouncing against a
// sliding-window reference model of the accepted key levels.
module tb_key_debounce8;

  localparam int D    = 4;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_n;
  logic       freeze;
  logic [7:0] key_db_n;
  logic [7:0] press;
  logic [7:0] key_release;
  logic       any_down;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] samp [0:MAXE];
  bit         elig [0:MAXE];
  int         e;
  logic [7:0] m_db;
  logic [7:0] m_press;
  logic [7:0] m_rel;
  logic       m_any;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  key_debounce8 #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .freeze(freeze),
    .key_db_n(key_db_n), .press(press), .key_release(key_release),
    .any_down(any_down)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if ((press | key_release) != 8'h00) obs_q.push_back({key_release, press});
  end

  // A key level is accepted at an edge when the synchronised input (the raw
  // sample two edges earlier) has differed from the accepted level on each of
  // the last D edges, none of which was a reset or frozen edge.
  task automatic model_edge(input logic [7:0] kn, input logic fr, input logic rs);
    bit hit;
    int idx;
    e++;
    if (e > MAXE) begin
      $display("FAIL model_capacity: edge %0d exceeds %0d", e, MAXE);
      $fatal(1, "model overflow");
    end
    m_press = 8'h00;
    m_rel   = 8'h00;
    if (rs) begin
      samp[e]   = 8'hFF;
      samp[e-1] = 8'hFF;
      elig[e]   = 1'b0;
      m_db      = 8'hFF;
    end else begin
      samp[e] = kn;
      elig[e] = !fr;
      for (int i = 0; i < 8; i++) begin
        hit = 1'b1;
        for (int k = 0; k < D; k++) begin
          idx = e - k;
          if (idx < 2) hit = 1'b0;
          else if (!elig[idx] || samp[idx-2][i] == m_db[i]) hit = 1'b0;
        end
        if (hit) begin
          if (m_db[i]) m_press[i] = 1'b1;
          else         m_rel[i]   = 1'b1;
          m_db[i] = ~m_db[i];
        end
      end
    end
    m_any = ~&m_db;
    if ((m_press | m_rel) != 8'h00) exp_q.push_back({m_rel, m_press});
  endtask

  // Driver: apply inputs, take one rising edge, advance the model.
  task automatic step(input logic [7:0] kn, input logic fr, input logic rs);
    key_n  = kn;
    freeze = fr;
    rst    = rs;
    @(posedge clk);
    model_edge(kn, fr, rs);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 1; c <= 2; c++) begin
      step(8'h00, 1'b0, 1'b1);
      n_vec++;
      if (key_db_n !== 8'hFF || press !== 8'h00 || key_release !== 8'h00 || any_down !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold c=%0d db=%h press=%h rel=%h any=%b want FF/00/00/0", c, key_db_n, press, key_release, any_down);
      end
    end
    for (int c = 1; c <= 7; c++) begin
      step(8'h00, 1'b0, 1'b0);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL reset_release c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      n_vec++;
      if ((c < 6 && key_db_n !== 8'hFF) || (c == 6 && (key_db_n !== 8'h00 || press !== 8'hFF))) begin
        n_err++;
        $display("FAIL reset_first_change c=%0d db=%h press=%h", c, key_db_n, press);
      end
    end
    for (int c = 1; c <= 7; c++) begin
      step(8'hFF, 1'b0, 1'b0);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL reset_restore c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
    end
  endtask

  task automatic test_single_press();
    for (int c = 1; c <= 15; c++) begin
      step((c <= 7) ? 8'hF7 : 8'hFF, 1'b0, 1'b0);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL single_press c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      if (c >= 5 && c <= 7) begin
        n_vec++;
        if ((c == 5 && key_db_n !== 8'hFF) ||
            (c == 6 && (key_db_n !== 8'hF7 || press !== 8'h08 || any_down !== 1'b1)) ||
            (c == 7 && (key_db_n !== 8'hF7 || press !== 8'h00))) begin
          n_err++;
          $display("FAIL single_press_timing c=%0d db=%h press=%h any=%b", c, key_db_n, press, any_down);
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        step((c < 3) ? 8'hDF : 8'hFF, 1'b0, 1'b0);
        n_vec++;
        if (key_db_n !== 8'hFF || press !== 8'h00 || key_db_n !== m_db) begin
          n_err++;
          $display("FAIL glitch r=%0d c=%0d db=%h/FF press=%h/00 model_db=%h", r, c, key_db_n, press, m_db);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 1; c <= 16; c++) begin
      step((c <= 8) ? 8'h7E : 8'hFF, 1'b0, 1'b0);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL two_keys c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      if (c == 6 || c == 14) begin
        n_vec++;
        if ((c == 6 && (key_db_n !== 8'h7E || press !== 8'h81)) ||
            (c == 14 && (key_db_n !== 8'hFF || key_release !== 8'h81 || any_down !== 1'b0))) begin
          n_err++;
          $display("FAIL two_keys_edge c=%0d db=%h press=%h rel=%h any=%b", c, key_db_n, press, key_release, any_down);
        end
      end
    end
  endtask

  task automatic test_freeze();
    for (int c = 1; c <= 20; c++) begin
      step((c <= 13) ? 8'hFB : 8'hFF, (c >= 4 && c <= 8), 1'b0);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL freeze c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      if (c <= 12) begin
        n_vec++;
        if ((c < 12 && key_db_n !== 8'hFF) || (c == 12 && (key_db_n !== 8'hFB || press !== 8'h04))) begin
          n_err++;
          $display("FAIL freeze_timing c=%0d db=%h press=%h", c, key_db_n, press);
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    for (int c = 1; c <= 18; c++) begin
      step((c <= 11) ? 8'hFD : 8'hFF, 1'b0, (c == 4));
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL reset_mid c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      if (c <= 10) begin
        n_vec++;
        if ((c < 10 && (key_db_n !== 8'hFF || press !== 8'h00)) || (c == 10 && (key_db_n !== 8'hFD || press !== 8'h02))) begin
          n_err++;
          $display("FAIL reset_mid_timing c=%0d db=%h press=%h", c, key_db_n, press);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] kn;
    logic [7:0] mask;
    int         fcnt;
    logic       rs;
    kn   = 8'hFF;
    fcnt = 0;
    for (int c = 0; c < 600; c++) begin
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      kn   = kn ^ mask;
      if (fcnt > 0) fcnt--;
      else if ($urandom_range(0, 49) == 0) fcnt = $urandom_range(1, 6);
      rs = ($urandom_range(0, 199) == 0);
      step(kn, (fcnt > 0), rs);
      n_vec++;
      if (key_db_n !== m_db || press !== m_press || key_release !== m_rel || any_down !== m_any) begin
        n_err++;
        $display("FAIL random c=%0d db=%h/%h press=%h/%h rel=%h/%h any=%b/%b", c, key_db_n, m_db, press, m_press, key_release, m_rel, any_down, m_any);
      end
      n_vec++;
      if ((press & key_release) !== 8'h00) begin
        n_err++;
        $display("FAIL random_exclusive c=%0d press=%h rel=%h want disjoint", c, press, key_release);
      end
    end
    for (int c = 0; c < 8; c++) step(8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_event_log();
    logic [15:0] want;
    logic [15:0] got;
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL event_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = obs_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL event got=%h want=%h", got, want);
      end
    end
  endtask

  initial begin
    key_n  = 8'hFF;
    freeze = 1'b0;
    rst    = 1'b1;
    e      = 1;
    samp[0] = 8'hFF;
    samp[1] = 8'hFF;
    elig[0] = 1'b0;
    elig[1] = 1'b0;
    m_db    = 8'hFF;
    m_press = 8'h00;
    m_rel   = 8'h00;
    m_any   = 1'b0;
    @(negedge clk);

    test_reset();
    test_single_press();
    test_glitch();
    test_back_to_back();
    test_freeze();
    test_reset_midcount();
    test_random();
    test_event_log();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
